// File: rtl/vjtag_pkg.sv
// rtl/vjtag_pkg.sv - shared constants, instruction codes and helpers for the virtual JTAG command controller
package vjtag_pkg;

  localparam int unsigned IR_W = 10;

  localparam logic [IR_W-1:0] IR_BYPASS = 10'h000;
  localparam logic [IR_W-1:0] IR_IDCODE = 10'h001;
  localparam logic [IR_W-1:0] IR_ADDR   = 10'h002;
  localparam logic [IR_W-1:0] IR_WRITE  = 10'h003;
  localparam logic [IR_W-1:0] IR_READ   = 10'h004;
  localparam logic [IR_W-1:0] IR_CLRERR = 10'h005;

  // Status bit positions inside ir_out; the low byte carries wr_count.
  localparam int unsigned ST_UNK_BIT = 9;
  localparam int unsigned ST_LEN_BIT = 8;

  typedef enum logic [2:0] {
    INS_BYPASS,
    INS_IDCODE,
    INS_ADDR,
    INS_WRITE,
    INS_READ,
    INS_CLRERR,
    INS_UNKNOWN
  } instr_e;

  function automatic int unsigned sr_width(input int unsigned data_w, input int unsigned addr_w);
    int unsigned w;
    w = 32;
    if (data_w > w) w = data_w;
    if (addr_w > w) w = addr_w;
    return w;
  endfunction

endpackage

// File: rtl/vjtag_cmd_ctrl.sv
// rtl/vjtag_cmd_ctrl.sv - virtual JTAG instruction decode, DR shift chain and register-bus access
module vjtag_cmd_ctrl
  import vjtag_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter logic [31:0] IDCODE_VAL = 32'h4A54_0001,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic [IR_W-1:0]   ir_in,
  output logic [IR_W-1:0]   ir_out,
  input  logic              vs_cdr,
  input  logic              vs_sdr,
  input  logic              vs_udr,
  input  logic              vs_uir,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam int unsigned SR_W     = sr_width(DATA_W, ADDR_W);
  localparam logic [6:0]  LEN_ADDR = 7'(ADDR_W);
  localparam logic [6:0]  LEN_DATA = 7'(DATA_W);

  instr_e            dec_ins;
  instr_e            ins_q, ins_d;
  logic [SR_W-1:0]   shift_reg_q, shift_reg_d;
  logic              bypass_q, bypass_d;
  logic [6:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              unk_err_q, unk_err_d;
  logic              len_err_q, len_err_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic [IR_W-1:0]   ir_out_q, ir_out_d;

  always_comb begin
    case (ir_in)
      IR_BYPASS: dec_ins = INS_BYPASS;
      IR_IDCODE: dec_ins = INS_IDCODE;
      IR_ADDR:   dec_ins = INS_ADDR;
      IR_WRITE:  dec_ins = INS_WRITE;
      IR_READ:   dec_ins = INS_READ;
      IR_CLRERR: dec_ins = INS_CLRERR;
      default:   dec_ins = INS_UNKNOWN;
    endcase
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      ins_q       <= INS_BYPASS;
      shift_reg_q <= '0;
      bypass_q    <= 1'b0;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      unk_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      wr_count_q  <= '0;
      ir_out_q    <= '0;
    end else begin
      ins_q       <= ins_d;
      shift_reg_q <= shift_reg_d;
      bypass_q    <= bypass_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      unk_err_q   <= unk_err_d;
      len_err_q   <= len_err_d;
      wr_count_q  <= wr_count_d;
      ir_out_q    <= ir_out_d;
    end
  end

  always_comb begin
    ins_d       = ins_q;
    shift_reg_d = shift_reg_q;
    bypass_d    = bypass_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = 1'b0;
    unk_err_d   = unk_err_q;
    len_err_d   = len_err_q;
    wr_count_d  = wr_count_q;

    if (vs_sdr) begin
      shift_reg_d = {tdi, shift_reg_q[SR_W-1:1]};
      bypass_d    = tdi;
      if (bit_cnt_q != 7'h7F) bit_cnt_d = bit_cnt_q + 7'd1;
    end

    // Captured words sit in the top L bits so the LSB is the first bit on tdo.
    if (vs_cdr) begin
      ins_d     = dec_ins;
      bit_cnt_d = '0;
      case (dec_ins)
        INS_IDCODE: shift_reg_d = SR_W'(IDCODE_VAL) << (SR_W - 32);
        INS_ADDR:   shift_reg_d = SR_W'(addr_q) << (SR_W - ADDR_W);
        INS_READ:   shift_reg_d = SR_W'(reg_rdata) << (SR_W - DATA_W);
        default:    ;
      endcase
    end

    // Post-write increment lands as the strobe ends so reg_addr holds the old address during it.
    if (AUTO_INC && wr_q) addr_d = addr_q + 1'b1;

    if (vs_udr) begin
      case (ins_q)
        INS_ADDR: begin
          if (bit_cnt_q == LEN_ADDR) addr_d = shift_reg_q[SR_W-1 -: ADDR_W];
          else len_err_d = 1'b1;
        end
        INS_WRITE: begin
          if (bit_cnt_q == LEN_DATA) begin
            wdata_d    = shift_reg_q[SR_W-1 -: DATA_W];
            wr_d       = 1'b1;
            wr_count_d = wr_count_q + 8'd1;
          end else begin
            len_err_d = 1'b1;
          end
        end
        INS_READ: begin
          if (AUTO_INC) addr_d = addr_q + 1'b1;
        end
        default: ;
      endcase
    end

    if (vs_uir) begin
      if (dec_ins == INS_UNKNOWN) unk_err_d = 1'b1;
      if (dec_ins == INS_CLRERR) begin
        unk_err_d  = 1'b0;
        len_err_d  = 1'b0;
        wr_count_d = '0;
      end
    end

    ir_out_d             = '0;
    ir_out_d[ST_UNK_BIT] = unk_err_d;
    ir_out_d[ST_LEN_BIT] = len_err_d;
    ir_out_d[7:0]        = wr_count_d;
  end

  always_comb begin
    case (ins_q)
      INS_IDCODE:          tdo = shift_reg_q[SR_W-32];
      INS_ADDR:            tdo = shift_reg_q[SR_W-ADDR_W];
      INS_WRITE, INS_READ: tdo = shift_reg_q[SR_W-DATA_W];
      default:             tdo = bypass_q;
    endcase
  end

  assign reg_rd    = vs_cdr && (dec_ins == INS_READ);
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign ir_out    = ir_out_q;

endmodule
